axis_header_parser: RTL

//  Receive-side counterpart of the header-injecting stream bridge. It consumes AXI-Stream packets

---
 rtl/axis_header_parser_if.sv | 12 +
 rtl/axis_header_parser.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_header_parser_if.sv
// AXI-Stream bundle shared by the header parser's input and payload output.
interface axis_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_header_parser.sv
// Strips and decodes a 6-word stream header, forwards the payload with a regenerated tlast.
// Optional packet statistics counters are built when AXIS_HDR_PARSER_STATS_EN is defined.
//
// state  | meaning
// S_HDR  | collecting header words 0..5 (hdr_idx selects the word)
// S_PAY  | zero-latency payload pass-through, counting beats against hdr_length
// S_DROP | discarding beats of a malformed packet until its tlast
module axis_header_parser #(
   parameter int          DATA_WIDTH = 16,
   parameter logic [15:0] MAGIC      = 16'hA55A
) (
   input  logic        aclk,
   input  logic        aresetn,
   axis_if.slave       s_axis,
   axis_if.master      m_axis,
   output logic [7:0]  hdr_instruction,
   output logic [4:0]  hdr_bram_start,
   output logic [4:0]  hdr_bram_end,
   output logic [15:0] hdr_addr_start,
   output logic [15:0] hdr_length,
   output logic        hdr_valid,
   output logic        pkt_done,
   output logic        err_magic,
   output logic        err_short,
   output logic        err_long,
   output logic        busy,
   output logic [15:0] pkt_ok_count,
   output logic [15:0] pkt_err_count
);

   localparam logic [1:0] S_HDR  = 2'd0;
   localparam logic [1:0] S_PAY  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready, m_valid, m_last, accept, last_beat;
   logic                  set_magic, set_short, set_long, hdr_load;

   logic [1:0]  state_q, state_d;
   logic [2:0]  hdr_idx_q, hdr_idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  sh_instr_q, sh_instr_d;
   logic [4:0]  sh_bstart_q, sh_bstart_d;
   logic [4:0]  sh_bend_q, sh_bend_d;
   logic [15:0] sh_addr_q, sh_addr_d;
   logic [7:0]  hdr_instruction_q, hdr_instruction_d;
   logic [4:0]  hdr_bram_start_q, hdr_bram_start_d;
   logic [4:0]  hdr_bram_end_q, hdr_bram_end_d;
   logic [15:0] hdr_addr_start_q, hdr_addr_start_d;
   logic [15:0] hdr_length_q, hdr_length_d;
   logic        hdr_valid_q, hdr_valid_d;
   logic        pkt_done_q, pkt_done_d;
   logic        err_magic_q, err_magic_d;
   logic        err_short_q, err_short_d;
   logic        err_long_q, err_long_d;

   assign s_data    = s_axis.tdata;
   assign accept    = s_axis.tvalid && s_ready;
   assign last_beat = (cnt_q == (hdr_length_q - 16'd1));

   always_comb begin
      state_d           = state_q;
      hdr_idx_d         = hdr_idx_q;
      cnt_d             = cnt_q;
      sh_instr_d        = sh_instr_q;
      sh_bstart_d       = sh_bstart_q;
      sh_bend_d         = sh_bend_q;
      sh_addr_d         = sh_addr_q;
      hdr_valid_d       = 1'b0;
      pkt_done_d        = 1'b0;
      set_magic         = 1'b0;
      set_short         = 1'b0;
      set_long          = 1'b0;
      hdr_load          = 1'b0;
      s_ready           = 1'b0;
      m_valid           = 1'b0;
      m_last            = 1'b0;
      case (state_q)
         S_HDR: begin
            s_ready = 1'b1;
            if (accept) begin
               if (hdr_idx_q == 3'd0) begin
                  if (s_data[15:0] != MAGIC) begin
                     set_magic = 1'b1;
                     if (s_axis.tlast) pkt_done_d = 1'b1;
                     else              state_d    = S_DROP;
                  end else if (s_axis.tlast) begin
                     set_short  = 1'b1;
                     pkt_done_d = 1'b1;
                  end else begin
                     hdr_idx_d = 3'd1;
                  end
               end else if (hdr_idx_q == 3'd5) begin
                  hdr_load    = 1'b1;
                  hdr_valid_d = 1'b1;
                  hdr_idx_d   = 3'd0;
                  cnt_d       = 16'd0;
                  if (s_data[15:0] == 16'd0) begin
                     if (s_axis.tlast) pkt_done_d = 1'b1;
                     else begin
                        set_long = 1'b1;
                        state_d  = S_DROP;
                     end
                  end else if (s_axis.tlast) begin
                     set_short  = 1'b1;
                     pkt_done_d = 1'b1;
                  end else begin
                     state_d = S_PAY;
                  end
               end else begin
                  case (hdr_idx_q)
                     3'd1:    sh_instr_d  = s_data[7:0];
                     3'd2:    sh_bstart_d = s_data[4:0];
                     3'd3:    sh_bend_d   = s_data[4:0];
                     default: sh_addr_d   = s_data[15:0];
                  endcase
                  if (s_axis.tlast) begin
                     set_short  = 1'b1;
                     pkt_done_d = 1'b1;
                     hdr_idx_d  = 3'd0;
                  end else begin
                     hdr_idx_d = hdr_idx_q + 3'd1;
                  end
               end
            end
         end
         S_PAY: begin
            m_valid = s_axis.tvalid;
            s_ready = m_axis.tready;
            m_last  = last_beat || s_axis.tlast;
            if (accept) begin
               if (last_beat) begin
                  if (s_axis.tlast) begin
                     pkt_done_d = 1'b1;
                     state_d    = S_HDR;
                  end else begin
                     set_long = 1'b1;
                     state_d  = S_DROP;
                  end
               end else if (s_axis.tlast) begin
                  set_short  = 1'b1;
                  pkt_done_d = 1'b1;
                  state_d    = S_HDR;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_DROP: begin
            s_ready = 1'b1;
            if (accept && s_axis.tlast) begin
               pkt_done_d = 1'b1;
               state_d    = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   // A new full header clears the sticky flags; errors found on that same beat still win.
   always_comb begin
      hdr_instruction_d = hdr_load ? sh_instr_q     : hdr_instruction_q;
      hdr_bram_start_d  = hdr_load ? sh_bstart_q    : hdr_bram_start_q;
      hdr_bram_end_d    = hdr_load ? sh_bend_q      : hdr_bram_end_q;
      hdr_addr_start_d  = hdr_load ? sh_addr_q      : hdr_addr_start_q;
      hdr_length_d      = hdr_load ? s_data[15:0]   : hdr_length_q;
      err_magic_d       = (err_magic_q && !hdr_load) || set_magic;
      err_short_d       = (err_short_q && !hdr_load) || set_short;
      err_long_d        = (err_long_q  && !hdr_load) || set_long;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q           <= S_HDR;
         hdr_idx_q         <= 3'd0;
         cnt_q             <= 16'd0;
         sh_instr_q        <= 8'd0;
         sh_bstart_q       <= 5'd0;
         sh_bend_q         <= 5'd0;
         sh_addr_q         <= 16'd0;
         hdr_instruction_q <= 8'd0;
         hdr_bram_start_q  <= 5'd0;
         hdr_bram_end_q    <= 5'd0;
         hdr_addr_start_q  <= 16'd0;
         hdr_length_q      <= 16'd0;
         hdr_valid_q       <= 1'b0;
         pkt_done_q        <= 1'b0;
         err_magic_q       <= 1'b0;
         err_short_q       <= 1'b0;
         err_long_q        <= 1'b0;
      end else begin
         state_q           <= state_d;
         hdr_idx_q         <= hdr_idx_d;
         cnt_q             <= cnt_d;
         sh_instr_q        <= sh_instr_d;
         sh_bstart_q       <= sh_bstart_d;
         sh_bend_q         <= sh_bend_d;
         sh_addr_q         <= sh_addr_d;
         hdr_instruction_q <= hdr_instruction_d;
         hdr_bram_start_q  <= hdr_bram_start_d;
         hdr_bram_end_q    <= hdr_bram_end_d;
         hdr_addr_start_q  <= hdr_addr_start_d;
         hdr_length_q      <= hdr_length_d;
         hdr_valid_q       <= hdr_valid_d;
         pkt_done_q        <= pkt_done_d;
         err_magic_q       <= err_magic_d;
         err_short_q       <= err_short_d;
         err_long_q        <= err_long_d;
      end
   end

`ifdef AXIS_HDR_PARSER_STATS_EN
   logic [15:0] pkt_ok_count_q, pkt_ok_count_d;
   logic [15:0] pkt_err_count_q, pkt_err_count_d;
   logic        pkt_bad;

   // S_DROP is only ever entered because of an error, so it marks the packet bad.
   always_comb begin
      pkt_bad         = set_magic || set_short || set_long || (state_q == S_DROP);
      pkt_ok_count_d  = pkt_ok_count_q;
      pkt_err_count_d = pkt_err_count_q;
      if (pkt_done_d && !pkt_bad && (pkt_ok_count_q != 16'hFFFF))
         pkt_ok_count_d = pkt_ok_count_q + 16'd1;
      if (pkt_done_d && pkt_bad && (pkt_err_count_q != 16'hFFFF))
         pkt_err_count_d = pkt_err_count_q + 16'd1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pkt_ok_count_q  <= 16'd0;
         pkt_err_count_q <= 16'd0;
      end else begin
         pkt_ok_count_q  <= pkt_ok_count_d;
         pkt_err_count_q <= pkt_err_count_d;
      end
   end

   assign pkt_ok_count  = pkt_ok_count_q;
   assign pkt_err_count = pkt_err_count_q;
`else
   assign pkt_ok_count  = 16'd0;
   assign pkt_err_count = 16'd0;
`endif

   assign s_axis.tready   = s_ready && aresetn;
   assign m_axis.tvalid   = m_valid && aresetn;
   assign m_axis.tlast    = m_last && aresetn;
   assign m_axis.tdata    = s_data;
   assign hdr_instruction = hdr_instruction_q;
   assign hdr_bram_start  = hdr_bram_start_q;
   assign hdr_bram_end    = hdr_bram_end_q;
   assign hdr_addr_start  = hdr_addr_start_q;
   assign hdr_length      = hdr_length_q;
   assign hdr_valid       = hdr_valid_q;
   assign pkt_done        = pkt_done_q;
   assign err_magic       = err_magic_q;
   assign err_short       = err_short_q;
   assign err_long        = err_long_q;
   assign busy            = (state_q != S_HDR) || (hdr_idx_q != 3'd0);

endmodule
